// File: rtl/pattern_checker_pkg.sv
// Shared types and helpers for the pattern checker: pattern selection,
// PRBS tap masks per supported word width, and a population count.
package pattern_checker_pkg;

    typedef enum logic [1:0] {
        PAT_COUNT = 2'd0,
        PAT_WALK  = 2'd1,
        PAT_PRBS  = 2'd2,
        PAT_FIXED = 2'd3
    } pattern_e;

    // Tap n (1-based) maps to mask bit n-1; feedback is the XOR of tapped bits.
    function automatic logic [63:0] prbs_taps(input int width);
        logic [63:0] taps;
        case (width)
            8:       taps = 64'h0000_0000_0000_00B8;
            16:      taps = 64'h0000_0000_0000_D008;
            32:      taps = 64'h0000_0000_8020_0003;
            64:      taps = 64'hD800_0000_0000_0000;
            default: taps = 64'h0000_0000_8020_0003;
        endcase
        return taps;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] value);
        logic [6:0] total;
        total = '0;
        for (int i = 0; i < 64; i++) begin
            total = total + {6'd0, value[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/pattern_gen.sv
// Reference word generator: holds the current expected word and the pattern
// mode latched at the last load, and advances one step per accepted beat.
module pattern_gen
    import pattern_checker_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              step,
    input  pattern_e          mode,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] word
);

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(prbs_taps(DATA_W));

    pattern_e          mode_q;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] step_word;

    // A zero seed would lock WALK and PRBS at zero forever, so substitute a live value.
    always_comb begin
        load_word = seed;
        if (seed == '0) begin
            if (mode == PAT_WALK) begin
                load_word = {{(DATA_W-1){1'b0}}, 1'b1};
            end else if (mode == PAT_PRBS) begin
                load_word = '1;
            end
        end
    end

    always_comb begin
        step_word = word;
        case (mode_q)
            PAT_COUNT: step_word = word + 1'b1;
            PAT_WALK:  step_word = {word[DATA_W-2:0], word[DATA_W-1]};
            PAT_PRBS:  step_word = {word[DATA_W-2:0], ^(word & TAPS)};
            PAT_FIXED: step_word = word;
            default:   step_word = word;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word   <= '0;
            mode_q <= PAT_COUNT;
        end else if (load) begin
            word   <= load_word;
            mode_q <= mode;
        end else if (step) begin
            word   <= step_word;
        end
    end

endmodule

// File: rtl/pattern_checker.sv
// Compares received beats against the reference generator, keeping saturating
// error/word counters and a capture of the first mismatch since clear.
module pattern_checker
    import pattern_checker_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 32,
    parameter bit BIT_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              restart,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] seed,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              check_en,
    output logic [CNT_W-1:0]  error_count,
    output logic [CNT_W-1:0]  word_count,
    output logic              mismatch,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_rcv
);

    localparam int               SUM_W   = CNT_W + 8;
    localparam logic [SUM_W-1:0] CNT_MAX = {8'd0, {CNT_W{1'b1}}};

    logic [DATA_W-1:0] expected;
    logic [DATA_W-1:0] diff;
    logic              beat;
    logic              checked;
    logic              is_mis;
    logic [6:0]        bit_errs;
    logic [6:0]        err_inc;
    logic [SUM_W-1:0]  err_sum;
    logic [SUM_W-1:0]  word_sum;
    logic [CNT_W-1:0]  err_next;
    logic [CNT_W-1:0]  word_next;

    pattern_gen #(.DATA_W(DATA_W)) u_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (restart),
        .step    (beat),
        .mode    (pattern_e'(pattern_sel)),
        .seed    (seed),
        .word    (expected)
    );

    // A restart cycle swallows any beat presented with it.
    assign beat     = data_valid & ~restart;
    assign checked  = beat & check_en;
    assign diff     = data_in ^ expected;
    assign is_mis   = checked & (diff != '0);
    assign bit_errs = popcount(64'(diff));

    // Sums are computed with headroom so saturation is a simple compare.
    always_comb begin
        err_inc   = BIT_MODE ? bit_errs : 7'd1;
        err_sum   = {8'd0, error_count} + SUM_W'(err_inc);
        word_sum  = {8'd0, word_count} + SUM_W'(1);
        err_next  = (err_sum > CNT_MAX) ? '1 : err_sum[CNT_W-1:0];
        word_next = (word_sum > CNT_MAX) ? '1 : word_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_count   <= '0;
            word_count    <= '0;
            mismatch      <= 1'b0;
            err_sticky    <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_rcv <= '0;
        end else begin
            mismatch <= is_mis;
            if (clear) begin
                error_count   <= '0;
                word_count    <= '0;
                err_sticky    <= 1'b0;
                first_err_idx <= '0;
                first_err_exp <= '0;
                first_err_rcv <= '0;
            end else begin
                if (checked) begin
                    word_count <= word_next;
                end
                if (is_mis) begin
                    error_count <= err_next;
                    if (!err_sticky) begin
                        err_sticky    <= 1'b1;
                        first_err_idx <= word_count;
                        first_err_exp <= expected;
                        first_err_rcv <= data_in;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_checker.sv
// Self-checking bench for pattern_checker: three instances (word mode, bit mode,
// 4-bit counters) share stimulus and are compared against a behavioural model.
module tb_pattern_checker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        restart;
    logic [1:0]  pattern_sel;
    logic [31:0] seed;
    logic        data_valid;
    logic [31:0] data_in;
    logic        check_en;

    logic [31:0] ec0, wc0, idx0, exp0, rcv0;
    logic        mis0, st0;
    logic [31:0] ec1, wc1, idx1, exp1, rcv1;
    logic        mis1, st1;
    logic [3:0]  ec2, wc2, idx2;
    logic [31:0] exp2, rcv2;
    logic        mis2, st2;

    logic [63:0] o_err [3];
    logic [63:0] o_wc  [3];
    logic [63:0] o_idx [3];
    logic [31:0] o_exp [3];
    logic [31:0] o_rcv [3];
    logic        o_mis [3];
    logic        o_st  [3];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_word;
    int          m_mode;
    logic [63:0] m_err [3];
    logic [63:0] m_wc  [3];
    logic [63:0] m_idx [3];
    logic [63:0] m_cap [3];
    logic        m_mis;
    logic        m_st;
    logic [31:0] m_exp;
    logic [31:0] m_rcv;

    pattern_checker #(.DATA_W(32), .CNT_W(32), .BIT_MODE(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .restart(restart),
        .pattern_sel(pattern_sel), .seed(seed), .data_valid(data_valid),
        .data_in(data_in), .check_en(check_en), .error_count(ec0),
        .word_count(wc0), .mismatch(mis0), .err_sticky(st0),
        .first_err_idx(idx0), .first_err_exp(exp0), .first_err_rcv(rcv0)
    );

    pattern_checker #(.DATA_W(32), .CNT_W(32), .BIT_MODE(1'b1)) dut_bit (
        .clk(clk), .reset_n(reset_n), .clear(clear), .restart(restart),
        .pattern_sel(pattern_sel), .seed(seed), .data_valid(data_valid),
        .data_in(data_in), .check_en(check_en), .error_count(ec1),
        .word_count(wc1), .mismatch(mis1), .err_sticky(st1),
        .first_err_idx(idx1), .first_err_exp(exp1), .first_err_rcv(rcv1)
    );

    pattern_checker #(.DATA_W(32), .CNT_W(4), .BIT_MODE(1'b0)) dut_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .restart(restart),
        .pattern_sel(pattern_sel), .seed(seed), .data_valid(data_valid),
        .data_in(data_in), .check_en(check_en), .error_count(ec2),
        .word_count(wc2), .mismatch(mis2), .err_sticky(st2),
        .first_err_idx(idx2), .first_err_exp(exp2), .first_err_rcv(rcv2)
    );

    always #5 clk = ~clk;

    always_comb begin
        o_err[0] = {32'd0, ec0};  o_wc[0] = {32'd0, wc0};  o_idx[0] = {32'd0, idx0};
        o_err[1] = {32'd0, ec1};  o_wc[1] = {32'd0, wc1};  o_idx[1] = {32'd0, idx1};
        o_err[2] = {60'd0, ec2};  o_wc[2] = {60'd0, wc2};  o_idx[2] = {60'd0, idx2};
        o_exp[0] = exp0; o_exp[1] = exp1; o_exp[2] = exp2;
        o_rcv[0] = rcv0; o_rcv[1] = rcv1; o_rcv[2] = rcv2;
        o_mis[0] = mis0; o_mis[1] = mis1; o_mis[2] = mis2;
        o_st[0]  = st0;  o_st[1]  = st1;  o_st[2]  = st2;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // LFSR with taps 32,22,2,1: shift left, feedback into bit 0.
    function automatic logic [31:0] prbs_next(input logic [31:0] s);
        int taps [4] = '{32, 22, 2, 1};
        logic fb = 1'b0;
        for (int i = 0; i < 4; i++) fb = fb ^ s[taps[i]-1];
        return {s[30:0], fb};
    endfunction

    function automatic logic [31:0] gen_next(input logic [31:0] w, input int mode);
        case (mode)
            0:       return w + 32'd1;
            1:       return (w << 1) | (w >> 31);
            2:       return prbs_next(w);
            default: return w;
        endcase
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] cap);
        return (a + b > cap) ? cap : a + b;
    endfunction

    task automatic model_reset();
        m_word = 32'd0;
        m_mode = 0;
        for (int k = 0; k < 3; k++) begin
            m_err[k] = 0; m_wc[k] = 0; m_idx[k] = 0;
        end
        m_mis = 1'b0; m_st = 1'b0; m_exp = 32'd0; m_rcv = 32'd0;
    endtask

    task automatic model_clock();
        logic beat, chk, mis;
        logic [31:0] expw;
        beat = data_valid && !restart;
        chk  = beat && check_en;
        expw = m_word;
        mis  = chk && (data_in !== expw);
        m_mis = mis;
        if (clear) begin
            for (int k = 0; k < 3; k++) begin
                m_err[k] = 0; m_wc[k] = 0; m_idx[k] = 0;
            end
            m_st = 1'b0; m_exp = 32'd0; m_rcv = 32'd0;
        end else begin
            if (mis && !m_st) begin
                for (int k = 0; k < 3; k++) m_idx[k] = m_wc[k];
                m_exp = expw; m_rcv = data_in; m_st = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                if (chk) m_wc[k] = sat_add(m_wc[k], 1, m_cap[k]);
                if (mis) m_err[k] = sat_add(m_err[k],
                    (k == 1) ? 64'($countones(data_in ^ expw)) : 64'd1, m_cap[k]);
            end
        end
        if (restart) begin
            m_mode = int'(pattern_sel);
            if (seed == 0 && pattern_sel == 2'd1)      m_word = 32'd1;
            else if (seed == 0 && pattern_sel == 2'd2) m_word = 32'hFFFF_FFFF;
            else                                       m_word = seed;
        end else if (beat) begin
            m_word = gen_next(m_word, m_mode);
        end
    endtask

    // Drive one clock cycle from a negedge; returns at the following negedge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic ce,
                         input logic rs, input logic cl, input logic [1:0] ps,
                         input logic [31:0] sd);
        data_valid = v; data_in = d; check_en = ce;
        restart = rs; clear = cl; pattern_sel = ps; seed = sd;
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_err[k] !== 0) begin errors++; $display("FAIL reset_err[%0d]: got %0h expected 0", k, o_err[k]); end
            checks++; if (o_wc[k] !== 0) begin errors++; $display("FAIL reset_wc[%0d]: got %0h expected 0", k, o_wc[k]); end
            checks++; if (o_mis[k] !== 1'b0) begin errors++; $display("FAIL reset_mis[%0d]: got %b expected 0", k, o_mis[k]); end
            checks++; if (o_st[k] !== 1'b0) begin errors++; $display("FAIL reset_sticky[%0d]: got %b expected 0", k, o_st[k]); end
            checks++; if (o_idx[k] !== 0 || o_exp[k] !== 0 || o_rcv[k] !== 0) begin
                errors++; $display("FAIL reset_capture[%0d]: got %0h/%0h/%0h expected 0/0/0", k, o_idx[k], o_exp[k], o_rcv[k]);
            end
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_count_seq();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 2'd0, 32'h5);
        for (int i = 0; i < 4; i++) cycle(1, 32'(5 + i), 1, 0, 0, 0, 0);
        checks++; if (ec0 !== 32'd0) begin errors++; $display("FAIL count_err: got %0d expected 0", ec0); end
        checks++; if (wc0 !== 32'd4) begin errors++; $display("FAIL count_wc: got %0d expected 4", wc0); end
        checks++; if (st0 !== 1'b0) begin errors++; $display("FAIL count_sticky: got %b expected 0", st0); end
    endtask

    task automatic test_first_error();
        logic [31:0] beats [4] = '{32'h0, 32'h1, 32'hFF, 32'h3};
        int pulses = 0;
        int pulse_at = -1;
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 2'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, beats[i], 1, 0, 0, 0, 0);
            if (mis0) begin pulses++; pulse_at = i; end
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        if (mis0) pulses++;
        checks++; if (pulses != 1 || pulse_at != 2) begin errors++; $display("FAIL first_pulses: got %0d at beat %0d expected 1 at beat 2", pulses, pulse_at); end
        checks++; if (ec0 !== 32'd1) begin errors++; $display("FAIL first_err: got %0d expected 1", ec0); end
        checks++; if (idx0 !== 32'd2) begin errors++; $display("FAIL first_idx: got %0d expected 2", idx0); end
        checks++; if (exp0 !== 32'h2) begin errors++; $display("FAIL first_exp: got %0h expected 2", exp0); end
        checks++; if (rcv0 !== 32'hFF) begin errors++; $display("FAIL first_rcv: got %0h expected ff", rcv0); end
        checks++; if (ec1 !== 32'd7) begin errors++; $display("FAIL first_bits: got %0d expected 7", ec1); end
        checks++; if (st0 !== 1'b1) begin errors++; $display("FAIL first_sticky: got %b expected 1", st0); end
    endtask

    task automatic test_bit_mode();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 2'd3, 32'h0);
        cycle(1, 32'h0000_000F, 1, 0, 0, 0, 0);
        checks++; if (ec1 !== 32'd4) begin errors++; $display("FAIL bitmode_err: got %0d expected 4", ec1); end
        checks++; if (ec0 !== 32'd1) begin errors++; $display("FAIL bitmode_word_err: got %0d expected 1", ec0); end
    endtask

    task automatic test_prbs();
        int flip;
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 2'd2, 32'h0);
        cycle(1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        for (int i = 1; i < 1000; i++) cycle(1, m_word, 1, 0, 0, 0, 0);
        checks++; if (ec0 !== 32'd0) begin errors++; $display("FAIL prbs_clean_err: got %0d expected 0", ec0); end
        checks++; if (wc0 !== 32'd1000) begin errors++; $display("FAIL prbs_clean_wc: got %0d expected 1000", wc0); end
        flip = $urandom_range(0, 31);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 2'd2, 32'h0);
        for (int i = 0; i < 1000; i++)
            cycle(1, (i == 500) ? (m_word ^ (32'd1 << flip)) : m_word, 1, 0, 0, 0, 0);
        checks++; if (ec0 !== 32'd1) begin errors++; $display("FAIL prbs_flip_err: got %0d expected 1", ec0); end
        checks++; if (idx0 !== 32'd500) begin errors++; $display("FAIL prbs_flip_idx: got %0d expected 500", idx0); end
        checks++; if (exp0 !== m_exp || rcv0 !== m_rcv) begin errors++; $display("FAIL prbs_flip_capture: got %0h/%0h expected %0h/%0h", exp0, rcv0, m_exp, m_rcv); end
    endtask

    task automatic test_saturation();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 2'd0, 32'h0);
        for (int i = 0; i < 20; i++) cycle(1, ~m_word, 1, 0, 0, 0, 0);
        checks++; if (ec2 !== 4'd15) begin errors++; $display("FAIL sat_err: got %0d expected 15", ec2); end
        checks++; if (wc2 !== 4'd15) begin errors++; $display("FAIL sat_wc: got %0d expected 15", wc2); end
        checks++; if (ec0 !== 32'd20) begin errors++; $display("FAIL sat_wide_err: got %0d expected 20", ec0); end
        cycle(1, ~m_word, 1, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_err[k] !== 0 || o_wc[k] !== 0 || o_st[k] !== 1'b0) begin
                errors++; $display("FAIL clear_wins[%0d]: got err %0h wc %0h sticky %b expected 0 0 0", k, o_err[k], o_wc[k], o_st[k]);
            end
            checks++; if (o_idx[k] !== 0 || o_exp[k] !== 0 || o_rcv[k] !== 0) begin
                errors++; $display("FAIL clear_capture[%0d]: got %0h/%0h/%0h expected 0/0/0", k, o_idx[k], o_exp[k], o_rcv[k]);
            end
        end
    endtask

    task automatic test_restart_discard();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 2'd0, 32'd10);
        cycle(1, 32'h1234, 1, 1, 0, 2'd0, 32'd10);
        cycle(1, 32'd10, 1, 0, 0, 0, 0);
        checks++; if (wc0 !== 32'd1) begin errors++; $display("FAIL discard_wc: got %0d expected 1", wc0); end
        checks++; if (ec0 !== 32'd0) begin errors++; $display("FAIL discard_err: got %0d expected 0", ec0); end
    endtask

    task automatic test_random();
        logic v, ce, rs, cl;
        logic [1:0] ps;
        logic [31:0] sd, d;
        cycle(0, 0, 0, 0, 1, 0, 0);
        for (int n = 0; n < 600; n++) begin
            v  = $urandom_range(0, 99) < 70;
            ce = $urandom_range(0, 4) != 0;
            rs = $urandom_range(0, 19) == 0;
            cl = $urandom_range(0, 29) == 0;
            ps = 2'($urandom_range(0, 3));
            sd = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom();
            d  = ($urandom_range(0, 2) == 0) ? (m_word ^ $urandom()) : m_word;
            cycle(v, d, ce, rs, cl, ps, sd);
            for (int k = 0; k < 3; k++) begin
                checks++; if (o_err[k] !== m_err[k]) begin errors++; $display("FAIL rand_err[%0d] cyc %0d: got %0h expected %0h", k, n, o_err[k], m_err[k]); end
                checks++; if (o_wc[k] !== m_wc[k]) begin errors++; $display("FAIL rand_wc[%0d] cyc %0d: got %0h expected %0h", k, n, o_wc[k], m_wc[k]); end
                checks++; if (o_mis[k] !== m_mis) begin errors++; $display("FAIL rand_mis[%0d] cyc %0d: got %b expected %b", k, n, o_mis[k], m_mis); end
                checks++; if (o_st[k] !== m_st) begin errors++; $display("FAIL rand_sticky[%0d] cyc %0d: got %b expected %b", k, n, o_st[k], m_st); end
                checks++; if (o_idx[k] !== m_idx[k]) begin errors++; $display("FAIL rand_idx[%0d] cyc %0d: got %0h expected %0h", k, n, o_idx[k], m_idx[k]); end
                checks++; if (o_exp[k] !== m_exp || o_rcv[k] !== m_rcv) begin
                    errors++; $display("FAIL rand_capture[%0d] cyc %0d: got %0h/%0h expected %0h/%0h", k, n, o_exp[k], o_rcv[k], m_exp, m_rcv);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 2'd1, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1, ~m_word, 1, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_err[k] !== 0 || o_wc[k] !== 0 || o_mis[k] !== 1'b0 || o_st[k] !== 1'b0) begin
                errors++; $display("FAIL async_counts[%0d]: got err %0h wc %0h mis %b sticky %b expected all 0", k, o_err[k], o_wc[k], o_mis[k], o_st[k]);
            end
            checks++; if (o_idx[k] !== 0 || o_exp[k] !== 0 || o_rcv[k] !== 0) begin
                errors++; $display("FAIL async_capture[%0d]: got %0h/%0h/%0h expected 0/0/0", k, o_idx[k], o_exp[k], o_rcv[k]);
            end
        end
        model_reset();
        data_valid = 1'b0; restart = 1'b0; clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1, 32'h0, 1, 0, 0, 0, 0);
        cycle(1, 32'h1, 1, 0, 0, 0, 0);
        checks++; if (ec0 !== 32'd0) begin errors++; $display("FAIL post_reset_err: got %0d expected 0", ec0); end
        checks++; if (wc0 !== 32'd2) begin errors++; $display("FAIL post_reset_wc: got %0d expected 2", wc0); end
    endtask

    initial begin
        m_cap[0] = 64'hFFFF_FFFF;
        m_cap[1] = 64'hFFFF_FFFF;
        m_cap[2] = 64'd15;
        reset_n = 1'b0; clear = 1'b0; restart = 1'b0; pattern_sel = 2'd0;
        seed = 32'd0; data_valid = 1'b0; data_in = 32'd0; check_en = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_count_seq();
        test_first_error();
        test_bit_mode();
        test_prbs();
        test_saturation();
        test_restart_discard();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
